// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: sequences single read/write accesses from an audio effect onto an
// asynchronous external SRAM used as a circular delay line. The write pointer advances by
// one 16-bit word per sample tick; reads/writes address a byte offset behind it.
// Optional feature: define DELAY_LINE_CLEAR_EN to zero the whole SRAM after every reset.
module delay_line_ctrl #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 12,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int RD_WAIT         = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_tick,
    input  logic                       rd,
    input  logic                       wr,
    input  logic [ADDR_WIDTH-1:0]      offset,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       read_finish,
    output logic                       write_finish,
    output logic                       busy,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0]      sram_dq_in,
    output logic [DATA_WIDTH-1:0]      sram_dq_out,
    output logic                       sram_dq_oe,
    output logic                       sram_ce_n,
    output logic                       sram_oe_n,
    output logic                       sram_we_n
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_SETUP = 3'd1;
    localparam logic [2:0] S_RD_WAIT  = 3'd2;
    localparam logic [2:0] S_RD_DONE  = 3'd3;
    localparam logic [2:0] S_WR_SETUP = 3'd4;
    localparam logic [2:0] S_WR_PULSE = 3'd5;
    localparam logic [2:0] S_WR_DONE  = 3'd6;
`ifdef DELAY_LINE_CLEAR_EN
    localparam logic [2:0] S_CLEAR    = 3'd7;
    // Highest even word address; the clear sweep ends after writing it.
    localparam logic [SRAM_ADDR_WIDTH-1:0] ADDR_TOP = ~SRAM_ADDR_WIDTH'(1);
`endif

    localparam logic [SRAM_ADDR_WIDTH-1:0] PTR_STEP  = SRAM_ADDR_WIDTH'(2);
    localparam logic [SRAM_ADDR_WIDTH-1:0] EVEN_MASK = ~SRAM_ADDR_WIDTH'(1);
    localparam logic [3:0]                 WAIT_LAST = 4'(RD_WAIT - 1);

    logic [2:0]                 state_q, state_d;
    logic [SRAM_ADDR_WIDTH-1:0] wr_ptr_q;
    logic [SRAM_ADDR_WIDTH-1:0] eff_addr;
    logic [3:0]                 wait_cnt_q;
    logic                       wait_done;
`ifdef DELAY_LINE_CLEAR_EN
    logic                       clr_phase_q;
    logic                       clr_last;
`endif

    // Effective address: offset bytes behind the write pointer, forced word-aligned.
    always_comb begin
        eff_addr  = (wr_ptr_q - SRAM_ADDR_WIDTH'(offset)) & EVEN_MASK;
        wait_done = (wait_cnt_q == WAIT_LAST);
`ifdef DELAY_LINE_CLEAR_EN
        clr_last  = clr_phase_q && (sram_addr == ADDR_TOP);
`endif
    end

    // Next-state decode; rd wins over wr, and strobes outside IDLE are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rd) begin
                    state_d = S_RD_SETUP;
                end else if (wr) begin
                    state_d = S_WR_SETUP;
                end
            end
            S_RD_SETUP: state_d = S_RD_WAIT;
            S_RD_WAIT:  state_d = wait_done ? S_RD_DONE : S_RD_WAIT;
            S_RD_DONE:  state_d = S_IDLE;
            S_WR_SETUP: state_d = S_WR_PULSE;
            S_WR_PULSE: state_d = S_WR_DONE;
            S_WR_DONE:  state_d = S_IDLE;
`ifdef DELAY_LINE_CLEAR_EN
            S_CLEAR:    state_d = clr_last ? S_IDLE : S_CLEAR;
`endif
            default:    state_d = S_IDLE;
        endcase
    end

    // State, write pointer and the per-access latched address/data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef DELAY_LINE_CLEAR_EN
            state_q     <= S_CLEAR;
            clr_phase_q <= 1'b0;
`else
            state_q     <= S_IDLE;
`endif
            wr_ptr_q    <= '0;
            wait_cnt_q  <= '0;
            data_out    <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else begin
            state_q <= state_d;

            // The pointer runs independently of the access FSM.
            if (sample_tick) begin
                wr_ptr_q <= wr_ptr_q + PTR_STEP;
            end

            if (state_q == S_RD_WAIT) begin
                wait_cnt_q <= wait_cnt_q + 4'd1;
            end else begin
                wait_cnt_q <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (rd) begin
                        sram_addr <= eff_addr;
                    end else if (wr) begin
                        sram_addr   <= eff_addr;
                        sram_dq_out <= data_in;
                    end
                end
                S_RD_WAIT: begin
                    if (wait_done) begin
                        data_out <= sram_dq_in;
                    end
                end
`ifdef DELAY_LINE_CLEAR_EN
                // sram_dq_out stays at its reset value of zero throughout the sweep.
                S_CLEAR: begin
                    clr_phase_q <= ~clr_phase_q;
                    if (clr_phase_q && !clr_last) begin
                        sram_addr <= sram_addr + PTR_STEP;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // SRAM strobes and completion pulses decoded from the current state.
    always_comb begin
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_dq_oe   = 1'b0;
        read_finish  = 1'b0;
        write_finish = 1'b0;
        busy         = (state_q != S_IDLE);
        case (state_q)
            S_RD_SETUP, S_RD_WAIT: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
            end
            S_RD_DONE: begin
                sram_ce_n   = 1'b0;
                read_finish = 1'b1;
            end
            S_WR_SETUP: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
            end
            S_WR_PULSE: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                sram_we_n  = 1'b0;
            end
            S_WR_DONE: begin
                sram_ce_n    = 1'b0;
                sram_dq_oe   = 1'b1;
                write_finish = 1'b1;
            end
`ifdef DELAY_LINE_CLEAR_EN
            // Reset parks the FSM in CLEAR, but the bus must stay idle while rst is high.
            S_CLEAR: begin
                if (!rst) begin
                    sram_ce_n  = 1'b0;
                    sram_dq_oe = 1'b1;
                    sram_we_n  = ~clr_phase_q;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule
